button_event_ctrl: RTL

//  Sequences N debounced push-buttons into a single event stream for the kitchen-timer FSM.

---
 rtl/button_event_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/button_event_ctrl.sv
// Turns debounced button pulses into SHORT/LONG/REPEAT events and round-robins them onto one valid/ready port.
// Latency: pulse -> pending slot next edge -> evt_valid the edge after; outputs hold while evt_valid & ~evt_ready.
module button_event_ctrl #(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = 100000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_state,
    input  logic [N_BTN-1:0] btn_down,
    input  logic [N_BTN-1:0] btn_up,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [2:0]       evt_btn,
    output logic [1:0]       evt_type,
    output logic             evt_drop
);
    localparam int MAX_MS = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int CW     = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;
    localparam int PSW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0]  REP_LAST  = CW'(REPEAT_MS - 1);
    localparam logic [PSW-1:0] PS_LAST   = PSW'(TICK_DIV - 1);
    localparam logic [1:0] EV_SHORT  = 2'b00;
    localparam logic [1:0] EV_LONG   = 2'b01;
    localparam logic [1:0] EV_REPEAT = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} st_t;

    logic [PSW-1:0]   presc;
    logic             tick;
    st_t              state     [N_BTN];
    st_t              state_nxt [N_BTN];
    logic [CW-1:0]    hold_cnt  [N_BTN];
    logic [CW-1:0]    hold_nxt  [N_BTN];
    logic [N_BTN-1:0] emit;
    logic [1:0]       emit_type [N_BTN];
    logic [N_BTN-1:0] slot_vld;
    logic [1:0]       slot_type [N_BTN];
    logic [N_BTN-1:0] drain;
    logic [2:0]       rr_ptr;
    logic             found;
    logic [2:0]       win;
    logic [1:0]       win_type;
    logic             load_en;
    logic             drop_any;

    assign tick = (presc == PS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PSW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i]    <= ST_IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
            end
        end
    end

    // btn_up wins over a simultaneous btn_down once a press is in progress
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold_cnt[i];
            emit[i]      = 1'b0;
            emit_type[i] = EV_SHORT;
            case (state[i])
                ST_IDLE: begin
                    if (btn_down[i] && !btn_up[i]) begin
                        state_nxt[i] = ST_PRESSED;
                        hold_nxt[i]  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (btn_up[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EV_SHORT;
                        state_nxt[i] = ST_IDLE;
                    end else if (!btn_state[i]) begin
                        state_nxt[i] = ST_IDLE;
                    end else if (tick) begin
                        if (hold_cnt[i] == LONG_LAST) begin
                            emit[i]      = 1'b1;
                            emit_type[i] = EV_LONG;
                            state_nxt[i] = ST_HELD;
                            hold_nxt[i]  = '0;
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + CW'(1);
                        end
                    end
                end
                ST_HELD: begin
                    if (btn_up[i] || !btn_state[i]) begin
                        state_nxt[i] = ST_IDLE;
                    end else if (tick) begin
                        if (hold_cnt[i] == REP_LAST) begin
                            emit[i]      = 1'b1;
                            emit_type[i] = EV_REPEAT;
                            hold_nxt[i]  = '0;
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + CW'(1);
                        end
                    end
                end
                default: state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // Round-robin: first pending slot at or above rr_ptr, else wrap to the lowest one
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_type = EV_SHORT;
        load_en  = !evt_valid || evt_ready;
        drain    = '0;
        drop_any = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!found && slot_vld[i] && (i >= int'(rr_ptr))) begin
                found    = 1'b1;
                win      = 3'(i);
                win_type = slot_type[i];
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (!found && slot_vld[i]) begin
                found    = 1'b1;
                win      = 3'(i);
                win_type = slot_type[i];
            end
        end
        for (int i = 0; i < N_BTN; i++) begin
            drain[i] = load_en && found && (win == 3'(i));
            if (emit[i] && slot_vld[i] && !drain[i]) begin
                drop_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                slot_type[i] <= EV_SHORT;
            end
            rr_ptr    <= '0;
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_type  <= '0;
            evt_drop  <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (emit[i] && (!slot_vld[i] || drain[i])) begin
                    slot_vld[i]  <= 1'b1;
                    slot_type[i] <= emit_type[i];
                end else if (drain[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            evt_drop <= drop_any;
            if (load_en) begin
                evt_valid <= found;
                if (found) begin
                    evt_btn  <= win;
                    evt_type <= win_type;
                    rr_ptr   <= (win == 3'(N_BTN - 1)) ? 3'd0 : win + 3'd1;
                end
            end
        end
    end
endmodule
